// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store stage.
// Data requests win every collision; each grant runs as one request/ack transaction with a timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wmask,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                bus_err,
    output logic [1:0]          dbgState
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   waitCnt;
    logic               ackOk;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    waitCnt <= '0;
                    if (dm_req) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wmask <= dm_wmask;
                    end else if (if_req) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // The transaction always ends in IDLE, so grants are separated by at least one idle cycle.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // A flushed fetch still completes on the bus; only its ready pulse is dropped.
    assign ackOk     = mem_ack & ~reset;
    assign if_ready  = (state == BUSY_I) & ackOk & if_req;
    assign dm_ready  = (state == BUSY_D) & ackOk & dm_req;
    assign if_rdata  = if_ready ? mem_rdata : '0;
    assign dm_rdata  = dm_ready ? mem_rdata : '0;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;
    assign dbgState  = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written timeout/reset sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wmask;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;
    logic [1:0]  dbgState;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err), .dbgState(dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver
    task automatic drive(input logic iq, input logic [31:0] ia, input logic dq, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic [3:0] dmk,
                         input logic ack, input logic [31:0] rd);
        if_req = iq; if_addr = ia; dm_req = dq; dm_we = dw; dm_addr = da;
        dm_wdata = dd; dm_wmask = dmk; mem_ack = ack; mem_rdata = rd;
    endtask

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        logic [3:0]  dmWmask;
        logic        memAck;
        logic [31:0] memRdata;
        logic        eMemReq;
        logic        eMemWe;
        logic [31:0] eMemAddr;
        logic [31:0] eMemWdata;
        logic [3:0]  eMemWmask;
        logic        eIfReady;
        logic        eDmReady;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    int          mOwner;
    int          mAge;
    logic        mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mWmask;
    logic        mErr;

    initial begin
        vec_t v;
        logic ackLive, lastIf, lastDm, eIfR, eDmR;

        reset = 1'b1;
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset mem_req", mem_req, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wmask", mem_wmask, 0);
        chk("reset bus_err", bus_err, 0);
        chk("reset if_ready", if_ready, 0);
        chk("reset dm_ready", dm_ready, 0);

        // ifReq ifAddr dmReq dmWe dmAddr dmWdata dmWmask ack rdata | eReq eWe eAddr eWdata eWmask eIfR eDmR
        v = '{'1, 32'h100, '0, '0, '0, '0, '0, '0, '0,           '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'1, 32'h100, '0, '0, '0, '0, '0, '0, '0,           '1, '0, 32'h100, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'1, 32'h100, '0, '0, '0, '0, '0, '1, 32'h00500093, '1, '0, 32'h100, '0, '0, '1, '0}; vecs.push_back(v);
        v = '{'1, 32'h104, '1, '0, 32'h2000, '0, '0, '0, '0,     '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'1, 32'h104, '1, '0, 32'h2000, '0, '0, '1, 32'h11, '1, '0, 32'h2000, '0, '0, '0, '1}; vecs.push_back(v);
        v = '{'1, 32'h104, '0, '0, '0, '0, '0, '0, '0,           '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'1, 32'h104, '0, '0, '0, '0, '0, '1, 32'h22,       '1, '0, 32'h104, '0, '0, '1, '0}; vecs.push_back(v);
        v = '{'0, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '0, '0, '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'0, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '0, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '0, '0}; vecs.push_back(v);
        v = '{'0, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '0, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '0, '0}; vecs.push_back(v);
        v = '{'0, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '1, '0, '1, '1, 32'h2004, 32'hDEADBEEF, 4'h3, '0, '1}; vecs.push_back(v);
        v = '{'0, '0, '0, '0, '0, '0, '0, '1, 32'h55,            '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'0, '0, '0, '0, '0, '0, '0, '0, '0,                '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'1, 32'h200, '0, '0, '0, '0, '0, '0, '0,           '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'0, 32'h200, '0, '0, '0, '0, '0, '0, '0,           '1, '0, 32'h200, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'0, 32'h200, '0, '0, '0, '0, '0, '1, 32'h33,       '1, '0, 32'h200, '0, '0, '0, '0}; vecs.push_back(v);
        v = '{'0, '0, '0, '0, '0, '0, '0, '0, '0,                '0, '0, '0, '0, '0, '0, '0}; vecs.push_back(v);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ifReq, vecs[i].ifAddr, vecs[i].dmReq, vecs[i].dmWe, vecs[i].dmAddr,
                  vecs[i].dmWdata, vecs[i].dmWmask, vecs[i].memAck, vecs[i].memRdata);
            #1;
            chk($sformatf("vec%0d mem_req", i), mem_req, vecs[i].eMemReq);
            if (vecs[i].eMemReq) begin
                chk($sformatf("vec%0d mem_we", i), mem_we, vecs[i].eMemWe);
                chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].eMemAddr);
                chk($sformatf("vec%0d mem_wmask", i), mem_wmask, vecs[i].eMemWmask);
                if (vecs[i].eMemWe)
                    chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].eMemWdata);
            end
            chk($sformatf("vec%0d if_ready", i), if_ready, vecs[i].eIfReady);
            chk($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].eIfReady ? vecs[i].memRdata : 32'h0);
            chk($sformatf("vec%0d dm_ready", i), dm_ready, vecs[i].eDmReady);
            chk($sformatf("vec%0d dm_rdata", i), dm_rdata, vecs[i].eDmReady ? vecs[i].memRdata : 32'h0);
            chk($sformatf("vec%0d stall_if", i), stall_if, vecs[i].ifReq & ~vecs[i].eIfReady);
            chk($sformatf("vec%0d stall_mem", i), stall_mem, vecs[i].dmReq & ~vecs[i].eDmReady);
            chk($sformatf("vec%0d bus_err", i), bus_err, 0);
        end

        // timeout: 15 busy cycles without ack, abort, spurious ack ignored, held request re-issued
        @(negedge clk); drive('0, '0, '1, '0, 32'h3000, '0, '0, '0, '0); #1;
        chk("to grant mem_req", mem_req, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk); #1;
            chk($sformatf("to busy%0d mem_req", k), mem_req, 1);
            chk($sformatf("to busy%0d bus_err", k), bus_err, 0);
        end
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h66; #1;
        chk("to abort bus_err", bus_err, 1);
        chk("to abort mem_req", mem_req, 0);
        chk("to abort dm_ready", dm_ready, 0);
        chk("to abort stall_mem", stall_mem, 1);
        @(negedge clk); mem_ack = 1'b0; #1;
        chk("to reissue mem_req", mem_req, 1);
        chk("to reissue mem_addr", mem_addr, 32'h3000);
        chk("to reissue bus_err", bus_err, 0);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h77; #1;
        chk("to done dm_ready", dm_ready, 1);
        chk("to done dm_rdata", dm_rdata, 32'h77);
        @(negedge clk); drive('0, '0, '0, '0, '0, '0, '0, '0, '0); #1;
        chk("to idle mem_req", mem_req, 0);

        // reset in BUSY_D, late ack ignored
        @(negedge clk); drive('0, '0, '1, '0, 32'h4000, '0, '0, '0, '0); #1;
        @(negedge clk); #1;
        chk("rst busy mem_req", mem_req, 1);
        @(negedge clk); reset = 1'b1; #1;
        chk("rst held stall_mem", stall_mem, 1);
        @(negedge clk); reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h88; #1;
        chk("rst after mem_req", mem_req, 0);
        chk("rst late ack dm_ready", dm_ready, 0);
        chk("rst late ack dm_rdata", dm_rdata, 0);
        @(negedge clk); mem_ack = 1'b0; #1;
        chk("rst regrant mem_req", mem_req, 1);
        chk("rst regrant mem_addr", mem_addr, 32'h4000);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h99; #1;
        chk("rst done dm_ready", dm_ready, 1);

        // randomized run against the transaction-level model
        @(negedge clk); reset = 1'b1; drive('0, '0, '0, '0, '0, '0, '0, '0, '0);
        mOwner = 0; mAge = 0; mErr = 1'b0; mWe = 1'b0; mAddr = '0; mWdata = '0; mWmask = '0;
        ackLive = 1'b1; lastIf = 1'b0; lastDm = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 50 == 0) ackLive = ($urandom_range(0, 3) != 0);
            if (dm_req && lastDm) dm_req = 1'b0;
            else if (!dm_req && $urandom_range(0, 3) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom;
                dm_wdata = $urandom; dm_wmask = 4'($urandom_range(0, 15));
            end
            if (if_req && (lastIf || $urandom_range(0, 15) == 0)) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            mem_ack   = ackLive && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            reset     = ($urandom_range(0, 249) == 0);
            #1;
            eIfR = !reset && mOwner == 1 && mem_ack && if_req;
            eDmR = !reset && mOwner == 2 && mem_ack && dm_req;
            chk("rnd mem_req", mem_req, mOwner != 0);
            if (mOwner != 0) begin
                chk("rnd mem_we", mem_we, mWe);
                chk("rnd mem_addr", mem_addr, mAddr);
                chk("rnd mem_wmask", mem_wmask, mWmask);
                if (mWe) chk("rnd mem_wdata", mem_wdata, mWdata);
            end
            chk("rnd if_ready", if_ready, eIfR);
            chk("rnd if_rdata", if_rdata, eIfR ? mem_rdata : 32'h0);
            chk("rnd dm_ready", dm_ready, eDmR);
            chk("rnd dm_rdata", dm_rdata, eDmR ? mem_rdata : 32'h0);
            chk("rnd stall_if", stall_if, if_req & ~eIfR);
            chk("rnd stall_mem", stall_mem, dm_req & ~eDmR);
            chk("rnd bus_err", bus_err, mErr);
            lastIf = eIfR;
            lastDm = eDmR;
            // advance the model by one clock
            if (reset) begin
                mOwner = 0; mErr = 1'b0;
            end else begin
                mErr = 1'b0;
                if (mOwner == 0) begin
                    mAge = 0;
                    if (dm_req) begin
                        mOwner = 2; mWe = dm_we; mAddr = dm_addr; mWdata = dm_wdata; mWmask = dm_wmask;
                    end else if (if_req) begin
                        mOwner = 1; mWe = 1'b0; mAddr = if_addr; mWmask = 4'h0;
                    end
                end else if (mem_ack) begin
                    mOwner = 0;
                end else begin
                    mAge++;
                    if (mAge == TIMEOUT) begin
                        mOwner = 0; mErr = 1'b1;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
